// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, fetch queue entry layout and fetch FSM states.
// MISALIGN_CHECK_EN adds the HALT state used when a misaligned redirect target is fetched.
package cpu_defs;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] INSN_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
    logic            mis;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

`ifdef MISALIGN_CHECK_EN
  typedef enum logic [1:0] {RUN, FULL, HALT} fetch_state_t;
`else
  typedef enum logic [1:0] {RUN, FULL} fetch_state_t;
`endif

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; a full queue accepts a push in the same cycle as a pop.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 97,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/insn_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and queues {pc, insn} toward decode.
// MISALIGN_CHECK_EN: misaligned redirect targets are fetched once, flagged, then fetch halts.
module insn_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              QUEUE_DEPTH = 2,
  parameter int              PC_STEP     = 4,
  localparam int             CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] mem_addr,
  input  logic [ILEN-1:0] mem_insn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_insn,
  output logic            out_misaligned
);
  logic [XLEN-1:0] pc_q, target;
  fetch_state_t    state_q, state_d;
  fetch_entry_t    wr_entry, head;
  logic            push, pop, full, empty, halted;
  logic [CW-1:0]   count, count_nxt;

`ifdef MISALIGN_CHECK_EN
  assign halted         = (state_q == HALT);
  assign target         = redirect_pc;
  assign wr_entry.mis   = (pc_q[1:0] != 2'b00);
`else
  assign halted         = 1'b0;
  assign target         = word_align(redirect_pc);
  assign wr_entry.mis   = 1'b0;
`endif
  assign wr_entry.pc    = pc_q;
  assign wr_entry.insn  = mem_insn;

  assign mem_addr = pc_q;
  assign pop      = out_valid & out_ready;
  assign push     = !redirect_valid && !halted && (!full || pop);
  assign count_nxt = count + CW'(push) - CW'(pop);

  fetch_queue #(.DEPTH(QUEUE_DEPTH), .W(ENTRY_W)) u_queue (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      state_q <= state_d;
      if (redirect_valid) pc_q <= target;
      else if (push)      pc_q <= pc_q + XLEN'(PC_STEP);
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = RUN;
`ifdef MISALIGN_CHECK_EN
    else if (state_q == HALT) state_d = HALT;
    else if (push && wr_entry.mis) state_d = HALT;
`endif
    else state_d = (count_nxt == CW'(QUEUE_DEPTH)) ? FULL : RUN;
  end

  // Head is gated so an empty queue presents zeros rather than stale storage.
  assign out_valid      = !empty;
  assign out_pc         = empty ? '0 : head.pc;
  assign out_insn       = empty ? '0 : head.insn;
  assign out_misaligned = !empty && head.mis;
endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed bench for insn_fetch_unit: expected accepted entries go into a scoreboard queue,
// a negedge monitor pops and compares every accepted head; direct checks cover timing.
module tb_insn_fetch_unit;
  import cpu_defs::*;

  logic            clk = 0;
  logic            reset;
  logic [XLEN-1:0] mem_addr;
  logic [ILEN-1:0] mem_insn;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid, out_ready, out_misaligned;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_insn;

  int nchecks = 0;
  int nerrors = 0;
  fetch_entry_t exp_q[$];

  insn_fetch_unit dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_insn(mem_insn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_insn(out_insn), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [ILEN-1:0] insn_of(input logic [XLEN-1:0] a);
    return (a == 64'h0) ? 32'h00A00093 : (a[31:0] ^ 32'h5A5A_0013);
  endfunction

  assign mem_insn = insn_of(mem_addr);

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    nchecks++;
    if (act !== req) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_entry(input logic [XLEN-1:0] pc, input logic mis);
    fetch_entry_t e;
    e.pc = pc; e.insn = insn_of(pc); e.mis = mis;
    exp_q.push_back(e);
  endtask

  // Monitor: every real acceptance must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        nchecks++; nerrors++;
        $display("FAIL unexpected_accept: got pc %h, expected no entry", out_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("acc_pc", out_pc, e.pc);
        chk("acc_insn", 64'(out_insn), 64'(e.insn));
        chk("acc_mis", 64'(out_misaligned), 64'(e.mis));
      end
    end
  end

  task automatic scoreboard_drained(input string name);
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset(input logic rdy);
    reset = 1; out_ready = rdy; redirect_valid = 0;
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_addr", mem_addr, 64'h0);
    step();
    chk("rst_pc", out_pc, 64'h0);
    chk("rst_insn", 64'(out_insn), 64'd0);
    chk("rst_mis", 64'(out_misaligned), 64'd0);
    scoreboard_drained("rst_pending");
    reset = 0;
  endtask

  // Redirect in the current cycle with ready=1; n entries are then accepted back to back.
  task automatic redirect(input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] exp_pc,
                          input logic mis, input int n);
    out_ready = 1; redirect_valid = 1; redirect_pc = tgt;
    step();
    redirect_valid = 0;
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_addr", mem_addr, exp_pc);
    for (int i = 0; i < n; i++) expect_entry(exp_pc + 64'(4 * i), mis);
    step();
    chk("redir_head_pc", out_pc, exp_pc);
    for (int i = 0; i < n; i++) step();
    out_ready = 0;
    scoreboard_drained("redir_drained");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    redirect_pc = '0;
    // 1: reset release and streaming
    do_reset(1'b1);
    expect_entry(64'h0, 1'b0);
    expect_entry(64'h4, 1'b0);
    chk("t1_addr_c0", mem_addr, 64'h0);
    chk("t1_valid_c0", 64'(out_valid), 64'd0);
    step();
    chk("t1_addr_c1", mem_addr, 64'h4);
    chk("t1_valid_c1", 64'(out_valid), 64'd1);
    chk("t1_pc_c1", out_pc, 64'h0);
    chk("t1_insn_c1", 64'(out_insn), 64'h00A00093);
    step();
    chk("t1_addr_c2", mem_addr, 64'h8);
    step();
    out_ready = 0;
    scoreboard_drained("t1_drained");

    // 2: backpressure fills queue with pc 0,4, then drain with no gaps
    do_reset(1'b0);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_addr", mem_addr, 64'h8);
      chk("t2_hold_pc", out_pc, 64'h0);
      chk("t2_hold_insn", 64'(out_insn), 64'h00A00093);
      step();
    end
    out_ready = 1;
    expect_entry(64'h0, 1'b0);
    expect_entry(64'h4, 1'b0);
    expect_entry(64'h8, 1'b0);
    step();
    chk("t2_gapless_pc", out_pc, 64'h4);
    step(); step();
    out_ready = 0;
    scoreboard_drained("t2_drained");

    // 3: redirect while full and ready (queue holds 12,16)
    chk("t3_full_pc", out_pc, 64'hC);
    redirect(64'h40, 64'h40, 1'b0, 2);

    // 4: wrap past top of address space
    redirect(64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 3);

    // 5: misaligned target
`ifdef MISALIGN_CHECK_EN
    redirect(64'h42, 64'h42, 1'b1, 1);
    out_ready = 1;
    step(); step();
    chk("t5_halted_valid", 64'(out_valid), 64'd0);
    chk("t5_halted_addr", mem_addr, 64'h46);
    redirect(64'h80, 64'h80, 1'b0, 2);
`else
    redirect(64'h42, 64'h40, 1'b0, 2);
`endif

    // 6: reset with queued entries
    step(); step(); step();
    chk("t6_valid_before", 64'(out_valid), 64'd1);
    reset = 1;
    step();
    chk("t6_valid_after", 64'(out_valid), 64'd0);
    chk("t6_addr_after", mem_addr, 64'h0);
    reset = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end
endmodule
